// File: rtl/image_pkg.sv
// Shared types and default geometry for the frame pixel source.
// Geometry defaults describe a 640x480 RGB444 frame.
package image_pkg;

  localparam int DEFAULT_DATA_WIDTH = 12;
  localparam int DEFAULT_IMG_WIDTH  = 640;
  localparam int DEFAULT_IMG_HEIGHT = 480;
  localparam int DEFAULT_ADDR_WIDTH = 19;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } src_state_t;

  // One stream beat: pixel plus end-of-line and start-of-frame tags.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] pix;
    logic                          eol;
    logic                          sof;
  } pix_beat_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry valid/ready FIFO; push and pop may happen in the same cycle.
// Head data appears the cycle after push and is held while pop_rdy is low.
module pixel_skid_fifo #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop_vld = (count_q != 2'd0);
  assign pop     = pop_vld && pop_rdy;
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  // The producer's credit scheme guarantees push never lands on a full FIFO.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_vld} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/frame_pixel_source.sv
// Streams one stored frame from a 1-cycle-latency memory as raster-ordered beats.
// First beat 3 cycles after start; reads stall on 2 outstanding credits under out_ready backpressure.
module frame_pixel_source #(
  parameter int DATA_WIDTH = image_pkg::DEFAULT_DATA_WIDTH,
  parameter int IMG_WIDTH  = image_pkg::DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = image_pkg::DEFAULT_IMG_HEIGHT,
  parameter int ADDR_WIDTH = image_pkg::DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  output logic                  pixel_edge,
  output logic                  pixel_sof,
  input  logic                  out_ready
);
  import image_pkg::*;

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  src_state_t            state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic                  tag_eol_q, tag_eol_d;
  logic                  tag_sof_q, tag_sof_d;

  logic                  fifo_vld;
  logic [DATA_WIDTH+1:0] fifo_dat;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic [2:0]            credit_used;
  logic                  last_col, last_row, last_addr;

  assign pop       = fifo_vld && out_ready;
  assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
  assign last_addr = (addr_q == ADDR_WIDTH'(NPIX - 1));

  // A beat leaving the FIFO this cycle frees its slot for the read issued now,
  // which is what lets the stream sustain one beat per cycle with only 2 entries.
  assign credit_used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    tag_eol_d  = tag_eol_q;
    tag_sof_d  = tag_sof_q;
    mem_rd_en  = 1'b0;
    done       = 1'b0;

    mem_rd_en  = (state_q == RUN) && (credit_used < 3'd2);
    inflight_d = mem_rd_en;

    if (mem_rd_en) begin
      tag_eol_d = last_col;
      tag_sof_d = (col_q == '0) && (row_q == '0);
      addr_d    = last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (mem_rd_en && last_addr) state_d = DRAIN;
      end
      DRAIN: begin
        // No reads remain, so the final beat is the sole FIFO entry with nothing in flight.
        if (pop && (fifo_count == 2'd1) && !inflight_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      tag_eol_q  <= 1'b0;
      tag_sof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      tag_eol_q  <= tag_eol_d;
      tag_sof_q  <= tag_sof_d;
    end
  end

  pixel_skid_fifo #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (inflight_q),
    .push_dat ({mem_rd_data, tag_eol_q, tag_sof_q}),
    .pop_vld  (fifo_vld),
    .pop_rdy  (out_ready),
    .pop_dat  (fifo_dat),
    .count    (fifo_count)
  );

  assign busy        = (state_q != IDLE);
  assign mem_addr    = addr_q;
  assign pixel_valid = fifo_vld;
  assign pixel_out   = fifo_dat[DATA_WIDTH+1:2];
  assign pixel_edge  = fifo_dat[1];
  assign pixel_sof   = fifo_dat[0];

endmodule

// File: tb/tb_frame_pixel_source.sv
// Directed bench for frame_pixel_source: a 4x3 instance and a 1x2 instance, each on a 1-cycle RAM with mem[a]=a.
module tb_frame_pixel_source;

  logic        clk;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // 4x3 instance
  logic        start, busy, done, mem_rd_en, pixel_valid, pixel_edge, pixel_sof, out_ready;
  logic [18:0] mem_addr;
  logic [11:0] mem_rd_data, pixel_out;

  // 1x2 instance
  logic        start1, busy1, done1, mem_rd_en1, pixel_valid1, pixel_edge1, pixel_sof1, ready1;
  logic [18:0] mem_addr1;
  logic [11:0] mem_rd_data1, pixel_out1;

  frame_pixel_source #(.DATA_WIDTH(12), .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_WIDTH(19)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .pixel_edge(pixel_edge),
    .pixel_sof(pixel_sof), .out_ready(out_ready)
  );

  frame_pixel_source #(.DATA_WIDTH(12), .IMG_WIDTH(1), .IMG_HEIGHT(2), .ADDR_WIDTH(19)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1),
    .pixel_out(pixel_out1), .pixel_valid(pixel_valid1), .pixel_edge(pixel_edge1),
    .pixel_sof(pixel_sof1), .out_ready(ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= mem_addr[11:0];
    if (mem_rd_en1) mem_rd_data1 <= mem_addr1[11:0];
  end

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, pixel_valid, pixel_out, pixel_edge, pixel_sof} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b addr=%0d vld=%b pix=%0d edge=%b sof=%b, want all 0",
               busy, done, mem_rd_en, mem_addr, pixel_valid, pixel_out, pixel_edge, pixel_sof);
    end
    checks++;
    if ({busy1, done1, mem_rd_en1, pixel_valid1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs_w1: got busy=%b done=%b rd=%b vld=%b, want 0", busy1, done1, mem_rd_en1, pixel_valid1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    int nb = 0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1; #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_on_start: got %b want 0", busy); end
    for (int cyc = 1; cyc < 40 && nb < 12; cyc++) begin
      @(negedge clk); start = 1'b0; #1;
      if (cyc == 1) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 19'd0 || busy !== 1'b1) begin
          errors++; $display("FAIL stream_first_read: rd=%b addr=%0d busy=%b want 1/0/1", mem_rd_en, mem_addr, busy);
        end
      end
      if (pixel_valid) begin
        checks++;
        if (cyc != 3 + nb) begin errors++; $display("FAIL stream_timing beat %0d: cycle %0d want %0d", nb, cyc, 3 + nb); end
        checks++;
        if (pixel_out !== 12'(nb)) begin errors++; $display("FAIL stream_data: got %0d want %0d", pixel_out, nb); end
        checks++;
        if (pixel_sof !== (nb == 0)) begin errors++; $display("FAIL stream_sof beat %0d: got %b", nb, pixel_sof); end
        checks++;
        if (pixel_edge !== (nb % 4 == 3)) begin errors++; $display("FAIL stream_edge beat %0d: got %b", nb, pixel_edge); end
        checks++;
        if (done !== (nb == 11)) begin errors++; $display("FAIL stream_done beat %0d: got %b want %b", nb, done, nb == 11); end
        nb++;
      end else begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL stream_done_idle: cycle %0d got 1 want 0", cyc); end
      end
    end
    checks++;
    if (nb != 12) begin errors++; $display("FAIL stream_count: got %0d beats want 12", nb); end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stream_after_done: busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_backpressure();
    logic [63:0] pat = 64'hA5C3_9F0E_6B21_D478;
    int          issued = 0;
    int          accepted = 0;
    bit          got_done = 1'b0;
    bit          prev_stall = 1'b0;
    bit          pop;
    logic [11:0] prev_out = '0;
    logic        prev_e = 1'b0, prev_s = 1'b0;
    @(negedge clk); start = 1'b1; out_ready = pat[0]; #1;
    for (int cyc = 1; cyc < 200 && !got_done; cyc++) begin
      @(negedge clk); start = 1'b0; out_ready = pat[cyc % 64]; #1;
      pop = pixel_valid && out_ready;
      if (prev_stall) begin
        checks++;
        if (!pixel_valid || pixel_out !== prev_out || pixel_edge !== prev_e || pixel_sof !== prev_s) begin
          errors++; $display("FAIL bp_hold: cycle %0d vld=%b pix=%0d want held %0d", cyc, pixel_valid, pixel_out, prev_out);
        end
      end
      if (mem_rd_en) begin
        checks++;
        if (issued - accepted - (pop ? 1 : 0) >= 2) begin
          errors++; $display("FAIL bp_credit: read issued with %0d outstanding, limit 2", issued - accepted);
        end
        checks++;
        if (mem_addr !== 19'(issued)) begin errors++; $display("FAIL bp_addr: got %0d want %0d", mem_addr, issued); end
        issued++;
      end
      if (pop) begin
        checks++;
        if (pixel_out !== 12'(accepted)) begin errors++; $display("FAIL bp_order: got %0d want %0d", pixel_out, accepted); end
        checks++;
        if (done !== (accepted == 11)) begin errors++; $display("FAIL bp_done: beat %0d done=%b", accepted, done); end
        got_done = done;
        accepted++;
      end
      prev_stall = pixel_valid && !out_ready;
      prev_out   = pixel_out;
      prev_e     = pixel_edge;
      prev_s     = pixel_sof;
    end
    checks++;
    if (accepted != 12 || issued != 12) begin
      errors++; $display("FAIL bp_totals: accepted %0d issued %0d want 12/12", accepted, issued);
    end
  endtask

  task automatic test_stall();
    int reads = 0;
    int nb = 0;
    @(negedge clk); start = 1'b1; out_ready = 1'b0; #1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk); start = 1'b0; #1;
      if (mem_rd_en) begin
        checks++;
        if (mem_addr !== 19'(reads)) begin errors++; $display("FAIL stall_read_addr: got %0d want %0d", mem_addr, reads); end
        reads++;
      end
    end
    checks++;
    if (reads != 2) begin errors++; $display("FAIL stall_read_count: got %0d want 2", reads); end
    checks++;
    if (pixel_valid !== 1'b1 || pixel_out !== 12'd0 || pixel_sof !== 1'b1) begin
      errors++; $display("FAIL stall_head: vld=%b pix=%0d sof=%b want 1/0/1", pixel_valid, pixel_out, pixel_sof);
    end
    checks++;
    if (mem_addr !== 19'd2) begin errors++; $display("FAIL stall_addr_held: got %0d want 2", mem_addr); end
    for (int cyc = 0; cyc < 30 && nb < 12; cyc++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (pixel_valid) begin
        checks++;
        if (pixel_out !== 12'(nb) || cyc != nb) begin
          errors++; $display("FAIL stall_resume: cycle %0d got %0d want %0d at cycle %0d", cyc, pixel_out, nb, nb);
        end
        nb++;
      end
    end
    checks++;
    if (nb != 12) begin errors++; $display("FAIL stall_count: got %0d beats want 12", nb); end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_restart();
    int  nb = 0;
    int  nb2 = 0;
    int  dones = 0;
    bit  fin = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      start = (cyc == 0 || cyc == 8 || cyc == 14 || cyc == 15);
      out_ready = 1'b1; #1;
      if (cyc == 8) begin
        checks++;
        if (pixel_valid !== 1'b1 || pixel_out !== 12'd5) begin
          errors++; $display("FAIL restart_beat5: vld=%b pix=%0d want 1/5", pixel_valid, pixel_out);
        end
      end
      if (cyc == 14) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL restart_done_cycle: done=%b want 1", done); end
      end
      if (cyc == 15) begin
        checks++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
          errors++; $display("FAIL restart_gap: busy=%b vld=%b want 0/0", busy, pixel_valid);
        end
      end
      if (pixel_valid && cyc < 15) begin
        checks++;
        if (pixel_out !== 12'(nb)) begin errors++; $display("FAIL restart_data: got %0d want %0d", pixel_out, nb); end
        nb++;
      end
      if (done) dones++;
    end
    checks++;
    if (nb != 12 || dones != 1) begin errors++; $display("FAIL restart_first_frame: beats %0d dones %0d want 12/1", nb, dones); end
    for (int cyc = 16; cyc < 60 && !fin; cyc++) begin
      @(negedge clk); start = 1'b0; #1;
      if (cyc == 16) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 19'd0) begin
          errors++; $display("FAIL restart_new_read: rd=%b addr=%0d want 1/0", mem_rd_en, mem_addr);
        end
      end
      if (pixel_valid) begin
        if (nb2 == 0) begin
          checks++;
          if (cyc != 18 || pixel_out !== 12'd0 || pixel_sof !== 1'b1) begin
            errors++; $display("FAIL restart_new_first: cycle %0d pix=%0d sof=%b want 18/0/1", cyc, pixel_out, pixel_sof);
          end
        end
        nb2++;
      end
      fin = done;
    end
    checks++;
    if (nb2 != 12 || !fin) begin errors++; $display("FAIL restart_second_frame: beats %0d done %b want 12/1", nb2, fin); end
  endtask

  task automatic test_reset_abort();
    bit bad = 1'b0;
    int nb = 0;
    bit fin = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); start = (cyc == 0); out_ready = 1'b1; #1;
    end
    checks++;
    if (pixel_valid !== 1'b1 || pixel_out !== 12'd6) begin
      errors++; $display("FAIL abort_beat6: vld=%b pix=%0d want 1/6", pixel_valid, pixel_out);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, pixel_valid, pixel_out, pixel_edge, pixel_sof} !== '0) begin
      errors++; $display("FAIL abort_async_zero: busy=%b done=%b rd=%b addr=%0d vld=%b pix=%0d want all 0",
                         busy, done, mem_rd_en, mem_addr, pixel_valid, pixel_out);
    end
    @(negedge clk); rst = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); start = 1'b0; #1;
      if (pixel_valid || mem_rd_en || busy || done) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_quiet: activity seen after reset with no start, want none"); end
    @(negedge clk); start = 1'b1; #1;
    for (int cyc = 1; cyc < 40 && !fin; cyc++) begin
      @(negedge clk); start = 1'b0; #1;
      if (cyc == 1) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 19'd0) begin
          errors++; $display("FAIL abort_restart_addr: rd=%b addr=%0d want 1/0", mem_rd_en, mem_addr);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (pixel_valid !== 1'b1 || pixel_out !== 12'd0 || pixel_sof !== 1'b1) begin
          errors++; $display("FAIL abort_restart_first: vld=%b pix=%0d sof=%b want 1/0/1", pixel_valid, pixel_out, pixel_sof);
        end
      end
      if (pixel_valid) nb++;
      fin = done;
    end
    checks++;
    if (nb != 12) begin errors++; $display("FAIL abort_restart_count: got %0d beats want 12", nb); end
  endtask

  task automatic test_width1();
    int nb = 0;
    @(negedge clk); start1 = 1'b1; ready1 = 1'b1; #1;
    for (int cyc = 1; cyc < 12 && nb < 2; cyc++) begin
      @(negedge clk); start1 = 1'b0; #1;
      if (pixel_valid1) begin
        checks++;
        if (cyc != 3 + nb || pixel_out1 !== 12'(nb)) begin
          errors++; $display("FAIL w1_data: cycle %0d pix=%0d want cycle %0d pix %0d", cyc, pixel_out1, 3 + nb, nb);
        end
        checks++;
        if (pixel_edge1 !== 1'b1) begin errors++; $display("FAIL w1_edge beat %0d: got %b want 1", nb, pixel_edge1); end
        checks++;
        if (pixel_sof1 !== (nb == 0)) begin errors++; $display("FAIL w1_sof beat %0d: got %b", nb, pixel_sof1); end
        checks++;
        if (done1 !== (nb == 1)) begin errors++; $display("FAIL w1_done beat %0d: got %b", nb, done1); end
        nb++;
      end
    end
    checks++;
    if (nb != 2) begin errors++; $display("FAIL w1_count: got %0d beats want 2", nb); end
  endtask

  initial begin
    start = 1'b0; out_ready = 1'b0; start1 = 1'b0; ready1 = 1'b0; rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_restart();
    test_reset_abort();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
